// File: rtl/bcedn_pack_adapter_if.sv
// Stream bus between the input FIFO read side, the pack adapter and the EC-1 stage.
// The adapter binds to the slave modport; the producer/consumer side binds to master.
interface bcedn_pack_adapter_if #(
    parameter int unsigned DATA_IN_WIDTH = 8,
    parameter int unsigned RATIO         = 4
);
    logic [DATA_IN_WIDTH-1:0]       data_in;
    logic                           in_en;
    logic                           in_rdy;
    logic [DATA_IN_WIDTH*RATIO-1:0] data_out;
    logic                           out_en;
    logic                           out_rdy;

    modport master (
        output data_in, in_en, out_rdy,
        input  in_rdy, data_out, out_en
    );

    modport slave (
        input  data_in, in_en, out_rdy,
        output in_rdy, data_out, out_en
    );
endinterface

// File: rtl/bcedn_pack_adapter.sv
// Packs a frame of narrow input words into RATIO-lane output words for EC-1, zero-padding
// a short last group, with a single output register and a one-cycle done pulse.
module bcedn_pack_adapter #(
    parameter int unsigned DATA_IN_WIDTH = 8,
    parameter int unsigned RATIO         = 4,
    parameter int unsigned FRAME_WORDS   = 1024,
    parameter bit          MSB_FIRST     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    bcedn_pack_adapter_if.slave  bus,
    output logic                 busy,
    output logic                 done
);
    localparam int unsigned DATA_OUT_WIDTH = DATA_IN_WIDTH * RATIO;
    localparam int unsigned OUT_WORDS      = (FRAME_WORDS + RATIO - 1) / RATIO;
    localparam int unsigned LANE_W         = $clog2(RATIO);
    localparam int unsigned IN_CNT_W       = $clog2(FRAME_WORDS + 1);
    localparam int unsigned OUT_CNT_W      = $clog2(OUT_WORDS + 1);

    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [IN_CNT_W-1:0]  LAST_IN   = IN_CNT_W'(FRAME_WORDS - 1);
    localparam logic [OUT_CNT_W-1:0] LAST_OUT  = OUT_CNT_W'(OUT_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

    state_e                    state_q;
    logic [LANE_W-1:0]         lane_q;
    logic [IN_CNT_W-1:0]       in_cnt_q;
    logic [OUT_CNT_W-1:0]      out_cnt_q;
    logic [DATA_OUT_WIDTH-1:0] acc_q;
    logic [DATA_OUT_WIDTH-1:0] data_out_q;
    logic                      out_en_q;

    logic                      last_word;
    logic                      group_end;
    logic                      in_rdy;
    logic                      accept;
    logic                      out_hs;
    logic [LANE_W-1:0]         idx;
    logic [DATA_OUT_WIDTH-1:0] merged;

    always_comb begin
        last_word = (in_cnt_q == LAST_IN);
        group_end = (lane_q == LAST_LANE) || last_word;
        out_hs    = out_en_q & bus.out_rdy;
        // Stall only a completing word while the single output register is still occupied.
        in_rdy    = (state_q == StFill) & ~(group_end & out_en_q & ~bus.out_rdy);
        accept    = bus.in_en & in_rdy;
        idx       = MSB_FIRST ? (LAST_LANE - lane_q) : lane_q;
        merged    = acc_q;
        merged[idx*DATA_IN_WIDTH +: DATA_IN_WIDTH] = bus.data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            lane_q     <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            acc_q      <= '0;
            data_out_q <= '0;
            out_en_q   <= 1'b0;
        end else begin
            if (out_hs) begin
                out_en_q  <= 1'b0;
                out_cnt_q <= out_cnt_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StFill;
                        lane_q    <= '0;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        acc_q     <= '0;
                    end
                end
                StFill: begin
                    if (accept) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (group_end) begin
                            // Unfilled lanes are already zero because acc_q is cleared per group.
                            data_out_q <= merged;
                            out_en_q   <= 1'b1;
                            lane_q     <= '0;
                            acc_q      <= '0;
                            if (last_word) begin
                                state_q <= StDrain;
                            end
                        end else begin
                            lane_q <= lane_q + 1'b1;
                            acc_q  <= merged;
                        end
                    end
                end
                StDrain: begin
                    if (out_hs && (out_cnt_q == LAST_OUT)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_rdy   = in_rdy;
    assign bus.data_out = data_out_q;
    assign bus.out_en   = out_en_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);

endmodule

// File: tb/tb_bcedn_pack_adapter.sv
// Bench for bcedn_pack_adapter: three instances (MSB-first/8, LSB-first/8, MSB-first/6) share
// stimulus; a negedge monitor logs accepted words and output handshakes for the scenario tasks.
module tb_bcedn_pack_adapter;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_en;
    logic       out_rdy;
    logic [7:0] data_in;

    always #5 clk = ~clk;

    bcedn_pack_adapter_if #(.DATA_IN_WIDTH(8), .RATIO(4)) if_a ();
    bcedn_pack_adapter_if #(.DATA_IN_WIDTH(8), .RATIO(4)) if_b ();
    bcedn_pack_adapter_if #(.DATA_IN_WIDTH(8), .RATIO(4)) if_c ();

    assign if_a.data_in = data_in;
    assign if_a.in_en   = in_en;
    assign if_a.out_rdy = out_rdy;
    assign if_b.data_in = data_in;
    assign if_b.in_en   = in_en;
    assign if_b.out_rdy = out_rdy;
    assign if_c.data_in = data_in;
    assign if_c.in_en   = in_en;
    assign if_c.out_rdy = out_rdy;

    logic [2:0]  irdy;
    logic [2:0]  oen;
    logic [2:0]  bsy;
    logic [2:0]  dn;
    logic [31:0] dout [3];

    assign irdy[0] = if_a.in_rdy;
    assign irdy[1] = if_b.in_rdy;
    assign irdy[2] = if_c.in_rdy;
    assign oen[0]  = if_a.out_en;
    assign oen[1]  = if_b.out_en;
    assign oen[2]  = if_c.out_en;
    assign dout[0] = if_a.data_out;
    assign dout[1] = if_b.data_out;
    assign dout[2] = if_c.data_out;

    bcedn_pack_adapter #(.DATA_IN_WIDTH(8), .RATIO(4), .FRAME_WORDS(8), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start), .bus(if_a), .busy(bsy[0]), .done(dn[0])
    );
    bcedn_pack_adapter #(.DATA_IN_WIDTH(8), .RATIO(4), .FRAME_WORDS(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start), .bus(if_b), .busy(bsy[1]), .done(dn[1])
    );
    bcedn_pack_adapter #(.DATA_IN_WIDTH(8), .RATIO(4), .FRAME_WORDS(6), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst(rst), .start(start), .bus(if_c), .busy(bsy[2]), .done(dn[2])
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  in_log  [3][1024];
    logic [31:0] out_log [3][1024];
    int in_n[3]     = '{0, 0, 0};
    int out_n[3]    = '{0, 0, 0};
    int done_n[3]   = '{0, 0, 0};
    int hold_err[3] = '{0, 0, 0};
    int hs_cyc[3]   = '{0, 0, 0};
    int done_cyc[3] = '{0, 0, 0};
    int cyc         = 0;
    logic [31:0] prev_dout[3];
    bit          prev_hold[3] = '{0, 0, 0};

    // Values seen at negedge are the ones the next rising edge acts on.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (prev_hold[i] && rst === 1'b1 && (oen[i] !== 1'b1 || dout[i] !== prev_dout[i]))
                hold_err[i]++;
            prev_hold[i] = (rst === 1'b1) && oen[i] && !out_rdy;
            prev_dout[i] = dout[i];
            if (rst === 1'b1 && in_en && irdy[i]) begin
                if (in_n[i] < 1024) in_log[i][in_n[i]] = data_in;
                in_n[i]++;
            end
            if (rst === 1'b1 && oen[i] && out_rdy) begin
                if (out_n[i] < 1024) out_log[i][out_n[i]] = dout[i];
                out_n[i]++;
                hs_cyc[i] = cyc;
            end
            if (dn[i] === 1'b1) begin
                done_n[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    function automatic int frame_of(int i);
        return (i == 2) ? 6 : 8;
    endfunction

    // Expected packed word: nv consecutive accepted words starting at base, in lane order.
    function automatic logic [31:0] pack_ref(int i, int base, int nv);
        logic [31:0] r;
        int          pos;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            if (j < nv) begin
                pos = (i == 1) ? j : 3 - j;
                r[pos*8 +: 8] = in_log[i][base + j];
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; in_en = 1'b0; out_rdy = 1'b1; data_in = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers n words starting at first, advancing when instance a accepts.
    task automatic feed(input logic [7:0] first, input int n);
        int  k = 0;
        int  g = 0;
        bit  acc;
        while (k < n && g < 200) begin
            data_in = first + 8'(k);
            in_en   = 1'b1;
            @(negedge clk);
            acc = irdy[0];
            tick();
            if (acc) k++;
            g++;
        end
        in_en = 1'b0;
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL feed_timeout: accepted %0d words, required %0d", k, n);
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bsy != 3'b000 && g < 200) begin
            tick();
            g++;
        end
        checks++;
        if (bsy != 3'b000) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b required 000", bsy);
        end
    endtask

    task automatic test_reset();
        int b0;
        rst = 1'b0; start = 1'b1; in_en = 1'b1; data_in = 8'hFF; out_rdy = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dout[i], oen[i], irdy[i], bsy[i], dn[i]} !== 36'h0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: data_out=%h out_en=%b in_rdy=%b busy=%b done=%b required all 0",
                         i, dout[i], oen[i], irdy[i], bsy[i], dn[i]);
            end
        end
        start = 1'b0;
        b0 = in_n[0];
        rst = 1'b1;
        repeat (5) tick();
        checks++;
        if (bsy !== 3'b000 || irdy !== 3'b000) begin
            errors++;
            $display("FAIL reset_stays_idle: busy=%b in_rdy=%b required 000/000", bsy, irdy);
        end
        checks++;
        if (in_n[0] != b0) begin
            errors++;
            $display("FAIL reset_no_accept: accepted %0d required 0", in_n[0] - b0);
        end
        in_en = 1'b0;
    endtask

    task automatic run_counting_frame();
        do_reset();
        pulse_start();
        feed(8'h01, 8);
        wait_idle();
    endtask

    task automatic test_pack();
        int bo = out_n[0];
        int bd = done_n[0];
        run_counting_frame();
        checks++;
        if (out_n[0] - bo != 2) begin
            errors++; $display("FAIL pack_count: got %0d required 2", out_n[0] - bo);
        end
        checks++;
        if (out_log[0][bo] !== 32'h01020304) begin
            errors++; $display("FAIL pack_word0: got %h required 01020304", out_log[0][bo]);
        end
        checks++;
        if (out_log[0][bo+1] !== 32'h05060708) begin
            errors++; $display("FAIL pack_word1: got %h required 05060708", out_log[0][bo+1]);
        end
        checks++;
        if (done_n[0] - bd != 1 || done_cyc[0] != hs_cyc[0] + 1) begin
            errors++;
            $display("FAIL pack_done: pulses %0d at cycle %0d, required 1 at cycle %0d",
                     done_n[0] - bd, done_cyc[0], hs_cyc[0] + 1);
        end
    endtask

    task automatic test_lane_order();
        int bo = out_n[1];
        run_counting_frame();
        checks++;
        if (out_n[1] - bo != 2) begin
            errors++; $display("FAIL lane_count: got %0d required 2", out_n[1] - bo);
        end
        checks++;
        if (out_log[1][bo] !== 32'h04030201) begin
            errors++; $display("FAIL lane_word0: got %h required 04030201", out_log[1][bo]);
        end
        checks++;
        if (out_log[1][bo+1] !== 32'h08070605) begin
            errors++; $display("FAIL lane_word1: got %h required 08070605", out_log[1][bo+1]);
        end
    endtask

    task automatic test_pad();
        int bo = out_n[2];
        int bi = in_n[2];
        int bd = done_n[2];
        run_counting_frame();
        checks++;
        if (out_n[2] - bo != 2 || in_n[2] - bi != 6) begin
            errors++;
            $display("FAIL pad_count: outputs %0d inputs %0d, required 2 and 6",
                     out_n[2] - bo, in_n[2] - bi);
        end
        checks++;
        if (out_log[2][bo] !== 32'h01020304) begin
            errors++; $display("FAIL pad_word0: got %h required 01020304", out_log[2][bo]);
        end
        checks++;
        if (out_log[2][bo+1] !== 32'h05060000) begin
            errors++; $display("FAIL pad_word1: got %h required 05060000", out_log[2][bo+1]);
        end
        checks++;
        if (done_n[2] - bd != 1 || done_cyc[2] != hs_cyc[2] + 1) begin
            errors++;
            $display("FAIL pad_done: pulses %0d at cycle %0d, required 1 at cycle %0d",
                     done_n[2] - bd, done_cyc[2], hs_cyc[2] + 1);
        end
    endtask

    task automatic test_back_pressure();
        int          bo, bi, bd, bh;
        int          k = 0;
        int          g = 0;
        int          stall_left = -1;
        int          stall_word = -1;
        logic [31:0] mid_dout = '0;
        bit          acc;
        do_reset();
        bo = out_n[0]; bi = in_n[0]; bd = done_n[0]; bh = hold_err[0];
        pulse_start();
        while (k < 8 && g < 200) begin
            data_in = 8'(k + 1);
            in_en   = 1'b1;
            @(negedge clk);
            acc = irdy[0];
            if (!irdy[0] && stall_word < 0) stall_word = k + 1;
            if (stall_left == 5) mid_dout = dout[0];
            tick();
            if (acc) k++;
            g++;
            if (stall_left < 0 && oen[0]) stall_left = 10;
            if (stall_left > 0) begin
                out_rdy = 1'b0;
                stall_left--;
            end else begin
                out_rdy = 1'b1;
            end
        end
        in_en   = 1'b0;
        out_rdy = 1'b1;
        wait_idle();
        checks++;
        if (stall_word != 8) begin
            errors++; $display("FAIL bp_stall_word: in_rdy first low on word %0d, required 8", stall_word);
        end
        checks++;
        if (mid_dout !== 32'h01020304) begin
            errors++; $display("FAIL bp_held_value: got %h required 01020304", mid_dout);
        end
        checks++;
        if (hold_err[0] != bh) begin
            errors++; $display("FAIL bp_hold_stable: %0d unstable cycles, required 0", hold_err[0] - bh);
        end
        checks++;
        if (in_n[0] - bi != 8 || out_n[0] - bo != 2 || done_n[0] - bd != 1) begin
            errors++;
            $display("FAIL bp_counts: in %0d out %0d done %0d, required 8 2 1",
                     in_n[0] - bi, out_n[0] - bo, done_n[0] - bd);
        end
        checks++;
        if (out_log[0][bo] !== 32'h01020304 || out_log[0][bo+1] !== 32'h05060708) begin
            errors++;
            $display("FAIL bp_words: got %h %h required 01020304 05060708",
                     out_log[0][bo], out_log[0][bo+1]);
        end
    endtask

    task automatic test_abort();
        int bd = done_n[0];
        int bo, bc;
        do_reset();
        pulse_start();
        feed(8'hA1, 3);
        rst = 1'b0;
        #1;
        checks++;
        if (bsy[0] !== 1'b0 || oen[0] !== 1'b0 || dout[0] !== 32'h0 || dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: busy=%b out_en=%b data_out=%h done=%b required 0",
                     bsy[0], oen[0], dout[0], dn[0]);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        bo = out_n[0];
        bc = out_n[2];
        pulse_start();
        feed(8'h11, 8);
        wait_idle();
        checks++;
        if (out_n[0] - bo != 2 || out_log[0][bo] !== 32'h11121314 || out_log[0][bo+1] !== 32'h15161718) begin
            errors++;
            $display("FAIL abort_new_frame: %0d words, %h %h required 2, 11121314 15161718",
                     out_n[0] - bo, out_log[0][bo], out_log[0][bo+1]);
        end
        checks++;
        if (out_log[2][bc] !== 32'h11121314) begin
            errors++; $display("FAIL abort_pad_first: got %h required 11121314", out_log[2][bc]);
        end
        checks++;
        if (done_n[0] - bd != 1) begin
            errors++; $display("FAIL abort_done_count: got %0d required 1", done_n[0] - bd);
        end
    endtask

    task automatic test_back_to_back();
        int bo = out_n[0];
        int bd;
        int g = 0;
        logic [31:0] exp [4];
        exp[0] = 32'h31323334; exp[1] = 32'h35363738;
        exp[2] = 32'h41424344; exp[3] = 32'h45464748;
        do_reset();
        bd = done_n[0];
        pulse_start();
        feed(8'h31, 8);
        while (dn[0] !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        pulse_start();
        feed(8'h41, 2);
        // A start while busy must not disturb the running frame.
        start   = 1'b1;
        data_in = 8'h43;
        in_en   = 1'b1;
        tick();
        start = 1'b0;
        feed(8'h44, 5);
        wait_idle();
        checks++;
        if (out_n[0] - bo != 4 || done_n[0] - bd != 2) begin
            errors++;
            $display("FAIL b2b_counts: outputs %0d done %0d, required 4 and 2",
                     out_n[0] - bo, done_n[0] - bd);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (out_log[0][bo+j] !== exp[j]) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h required %h", j, out_log[0][bo+j], exp[j]);
            end
        end
    endtask

    task automatic test_random();
        int bi[3], bo[3], bd[3], bh[3];
        int g, f, nout;
        logic [31:0] e;
        do_reset();
        for (int fr = 0; fr < 10; fr++) begin
            for (int i = 0; i < 3; i++) begin
                bi[i] = in_n[i]; bo[i] = out_n[i]; bd[i] = done_n[i]; bh[i] = hold_err[i];
            end
            pulse_start();
            g = 0;
            while (bsy != 3'b000 && g < 600) begin
                in_en   = ($urandom_range(0, 3) != 0);
                data_in = 8'($urandom);
                out_rdy = ($urandom_range(0, 2) != 0);
                tick();
                g++;
            end
            in_en   = 1'b0;
            out_rdy = 1'b1;
            wait_idle();
            for (int i = 0; i < 3; i++) begin
                f    = frame_of(i);
                nout = (f + 3) / 4;
                checks++;
                if (in_n[i] - bi[i] != f || out_n[i] - bo[i] != nout || done_n[i] - bd[i] != 1) begin
                    errors++;
                    $display("FAIL rand_counts[%0d] frame %0d: in %0d out %0d done %0d, required %0d %0d 1",
                             i, fr, in_n[i] - bi[i], out_n[i] - bo[i], done_n[i] - bd[i], f, nout);
                end
                checks++;
                if (hold_err[i] != bh[i]) begin
                    errors++;
                    $display("FAIL rand_hold[%0d] frame %0d: %0d unstable cycles, required 0",
                             i, fr, hold_err[i] - bh[i]);
                end
                for (int j = 0; j < nout; j++) begin
                    e = pack_ref(i, bi[i] + 4 * j, (f - 4 * j < 4) ? f - 4 * j : 4);
                    checks++;
                    if (out_log[i][bo[i]+j] !== e) begin
                        errors++;
                        $display("FAIL rand_word[%0d] frame %0d word %0d: got %h required %h",
                                 i, fr, j, out_log[i][bo[i]+j], e);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_lane_order();
        test_pad();
        test_back_pressure();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
